pipeline_stall_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It replaces the scattered per-stage enables with one controller that arbitrates three hazard sources: load-use, taken branch/jump, and a multi-cycle data memory with a ready handshake. The pipeline control outputs are combinational from the current state and inputs. A small FSM tracks outstanding memory waits, enforces a timeout, and keeps saturating performance counters.

---
 rtl/pipeline_stall_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
//   Central stall/flush sequencer for the 5-stage RISC-V pipeline. It arbitrates
//   three hazard sources (in priority order):
//     1. data-memory freeze: the MEM stage is waiting on mem_ready. The whole
//        pipe holds and a bubble goes into MEM/WB.
//     2. taken branch/jump in EX: IF/ID and ID/EX are flushed and the PC
//        redirects.
//     3. load-use in ID: PC and IF/ID hold for one cycle and ID/EX gets a bubble.
//   All pipeline control outputs are combinational from state and inputs.
//   A small FSM (RUN / MEM_WAIT / ERROR) tracks outstanding memory waits and
//   enforces a timeout. Two saturating performance counters are kept.
//
// Parameters
//   MEM_TIMEOUT  max consecutive MEM_WAIT cycles before ERROR (0 = no timeout)
//   CNT_W        width of the performance counters
//
// Ports
//   clk, rst                      clock, async active-high reset
//   id_rs1/id_rs2, id_uses_rs*    ID-stage source registers and their use flags
//   ex_rd, ex_mem_read            EX destination register and load flag
//   ex_branch_taken               EX branch/jump resolved taken
//   mem_req, mem_ready            MEM-stage data-memory handshake
//   pc_write, if_id_write,
//   id_ex_write, ex_mem_write     register enables
//   if_id_flush, id_ex_flush      NOP/bubble insertion
//   mem_wb_bubble                 suppress writeback in MEM/WB
//   mem_err                       sticky memory-timeout error
//   stall_cnt, flush_cnt          saturating performance counters
module pipeline_stall_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             mem_wb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  // Wide enough to hold MEM_TIMEOUT itself; with the timeout disabled the
  // counter simply saturates.
  localparam int              WAIT_W = $clog2(MEM_TIMEOUT + 2);
  localparam logic [WAIT_W-1:0] TO_VAL = WAIT_W'(MEM_TIMEOUT);
  localparam bit              TO_EN  = (MEM_TIMEOUT != 0);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;

  logic load_use;
  logic freeze;
  logic branch_fire;
  logic lu_stall;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  // x0 never carries a real dependency, and a source the ID op does not read
  // cannot create one.
  always_comb begin
    load_use = 1'b0;
    if (ex_mem_read && (ex_rd != 5'd0)) begin
      load_use = (id_uses_rs1 && (ex_rd == id_rs1)) ||
                 (id_uses_rs2 && (ex_rd == id_rs2));
    end
  end

  // In RUN the freeze starts on the very cycle the access misses, not one
  // cycle later, so the pipe never advances past an incomplete access.
  // ERROR behaves as a permanent freeze.
  always_comb begin
    freeze = 1'b0;
    case (state)
      RUN:      freeze = mem_req && !mem_ready;
      MEM_WAIT: freeze = !mem_ready;
      ERROR:    freeze = 1'b1;
      default:  freeze = 1'b0;
    endcase
  end

  // A taken branch squashes the dependent ID instruction, so it wins over
  // load-use. Neither applies while frozen: EX is not advancing.
  assign branch_fire = !freeze && ex_branch_taken;
  assign lu_stall    = !freeze && !ex_branch_taken && load_use;

  // ---------------------------------------------------------------------------
  // Pipeline control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    mem_wb_bubble = 1'b0;
    if (rst) begin
      // Hold every register while in reset and insert no bubbles.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (freeze) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (branch_fire) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (lu_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  assign mem_err = (state == ERROR);

  // ---------------------------------------------------------------------------
  // Memory-wait FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // wait_cnt counts freeze cycles spent in MEM_WAIT. It is 1 on the first
  // MEM_WAIT cycle, so timing out at wait_cnt==MEM_TIMEOUT yields exactly
  // MEM_TIMEOUT MEM_WAIT cycles, following the RUN entry cycle.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        // mem_req is intentionally ignored here; the access is already issued.
        if (mem_ready) begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end else if (TO_EN && (wait_cnt == TO_VAL)) begin
          state_nxt = ERROR;
          wait_nxt  = '0;
        end else if (wait_cnt != '1) begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      ERROR: begin
        state_nxt = ERROR;
      end
      default: begin
        state_nxt = RUN;
        wait_nxt  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = freeze || lu_stall;
  assign flush_inc = branch_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl (MEM_TIMEOUT=4, CNT_W=4).
// Inputs change 1ns after each rising edge; outputs are sampled on the
// falling edge. Each expected entry holds the control vector plus mem_err and
// both counters as they should read at that falling edge.
module tb_pipeline_stall_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic       mem_req, mem_ready;
  logic       pc_write, if_id_write, if_id_flush, id_ex_flush;
  logic       id_ex_write, ex_mem_write, mem_wb_bubble, mem_err;
  logic [3:0] stall_cnt, flush_cnt;

  pipeline_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write),
    .mem_wb_bubble(mem_wb_bubble), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, br, mreq, mrdy;
  } stim_t;

  // ctl = {pc_write, if_id_write, if_id_flush, id_ex_flush,
  //        id_ex_write, ex_mem_write, mem_wb_bubble}
  typedef struct packed {
    logic [6:0] ctl;
    logic       err;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  localparam logic [6:0] DEF = 7'b1100110;
  localparam logic [6:0] LU  = 7'b0001110;
  localparam logic [6:0] BR  = 7'b1111110;
  localparam logic [6:0] FRZ = 7'b0000001;
  localparam logic [6:0] RST = 7'b0000000;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // lu=1 drives a load to x5 in EX with ID reading x5 through rs2.
  function automatic stim_t mk(input logic r, input logic lu, input logic br,
                               input logic mreq, input logic mrdy);
    stim_t s;
    s      = '0;
    s.rst  = r;
    s.rs1  = 5'd3;
    s.u1   = 1'b1;
    if (lu) begin
      s.rd  = 5'd5;
      s.rs2 = 5'd5;
      s.u2  = 1'b1;
      s.mr  = 1'b1;
    end
    s.br   = br;
    s.mreq = mreq;
    s.mrdy = mrdy;
    return s;
  endfunction

  function automatic exp_t ex(input logic [6:0] c, input logic err,
                              input int sc, input int fc);
    exp_t e;
    e.ctl = c;
    e.err = err;
    e.sc  = 4'(sc);
    e.fc  = 4'(fc);
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t o;
    o.ctl = {pc_write, if_id_write, if_id_flush, id_ex_flush,
             id_ex_write, ex_mem_write, mem_wb_bubble};
    o.err = mem_err;
    o.sc  = stall_cnt;
    o.fc  = flush_cnt;
    return o;
  endfunction

  task automatic drive(input stim_t s, input exp_t e);
    rst             = s.rst;
    id_rs1          = s.rs1;
    id_rs2          = s.rs2;
    id_uses_rs1     = s.u1;
    id_uses_rs2     = s.u2;
    ex_rd           = s.rd;
    ex_mem_read     = s.mr;
    ex_branch_taken = s.br;
    mem_req         = s.mreq;
    mem_ready       = s.mrdy;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    drive(mk(1, 0, 0, 0, 0), ex(RST, 0, 0, 0));
    void'(sb.pop_back());
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    exp_t got, e;
    // Hazard inputs present during reset must not leak through.
    drive(mk(1, 1, 1, 1, 0), ex(RST, 0, 0, 0));
    @(negedge clk); got = sample(); e = sb.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL reset_hold got=%h exp=%h", got, e); end
    @(posedge clk); #1;
    drive(mk(0, 0, 0, 0, 0), ex(DEF, 0, 0, 0));
    @(negedge clk); got = sample(); e = sb.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL reset_release got=%h exp=%h", got, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    stim_t s[$];
    exp_t  q[$];
    exp_t  got, e;
    do_reset();
    s.push_back(mk(0, 1, 0, 0, 0)); q.push_back(ex(LU,  0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0)); q.push_back(ex(DEF, 0, 1, 0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i], q[i]);
      @(negedge clk); got = sample(); e = sb.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL load_use[%0d] got=%h exp=%h", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_x0_unused();
    stim_t s[$];
    exp_t  q[$];
    exp_t  got, e;
    stim_t t;
    do_reset();
    t = mk(0, 0, 0, 0, 0); t.mr = 1; t.rd = 0; t.rs1 = 0; t.u1 = 1;
    s.push_back(t); q.push_back(ex(DEF, 0, 0, 0));
    t = mk(0, 0, 0, 0, 0); t.mr = 1; t.rd = 7; t.rs1 = 7; t.u1 = 0;
    s.push_back(t); q.push_back(ex(DEF, 0, 0, 0));
    t = mk(0, 0, 0, 0, 0); t.mr = 1; t.rd = 7; t.rs1 = 7; t.u1 = 1;
    s.push_back(t); q.push_back(ex(LU, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0)); q.push_back(ex(DEF, 0, 1, 0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i], q[i]);
      @(negedge clk); got = sample(); e = sb.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL x0_unused[%0d] got=%h exp=%h", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    stim_t s[$];
    exp_t  q[$];
    exp_t  got, e;
    do_reset();
    s.push_back(mk(0, 1, 1, 0, 0)); q.push_back(ex(BR,  0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0)); q.push_back(ex(DEF, 0, 0, 1));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i], q[i]);
      @(negedge clk); got = sample(); e = sb.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL branch[%0d] got=%h exp=%h", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_wait();
    stim_t s[$];
    exp_t  q[$];
    exp_t  got, e;
    do_reset();
    // Three-cycle access: RUN entry plus two MEM_WAIT cycles, mem_req dropped
    // in MEM_WAIT must not end the wait.
    s.push_back(mk(0, 0, 0, 1, 0)); q.push_back(ex(FRZ, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 1, 0)); q.push_back(ex(FRZ, 0, 1, 0));
    s.push_back(mk(0, 0, 0, 0, 0)); q.push_back(ex(FRZ, 0, 2, 0));
    s.push_back(mk(0, 0, 0, 1, 1)); q.push_back(ex(DEF, 0, 3, 0));
    s.push_back(mk(0, 0, 0, 0, 0)); q.push_back(ex(DEF, 0, 3, 0));
    // Single-cycle access in RUN: no freeze, no state change.
    s.push_back(mk(0, 0, 0, 1, 1)); q.push_back(ex(DEF, 0, 3, 0));
    s.push_back(mk(0, 0, 0, 0, 0)); q.push_back(ex(DEF, 0, 3, 0));
    // Branch and load-use during freeze are ignored; load-use resolves on
    // the first unfrozen cycle.
    s.push_back(mk(0, 1, 1, 1, 0)); q.push_back(ex(FRZ, 0, 3, 0));
    s.push_back(mk(0, 1, 0, 0, 1)); q.push_back(ex(LU,  0, 4, 0));
    s.push_back(mk(0, 0, 0, 0, 0)); q.push_back(ex(DEF, 0, 5, 0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i], q[i]);
      @(negedge clk); got = sample(); e = sb.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL mem_wait[%0d] got=%h exp=%h", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    stim_t s[$];
    exp_t  q[$];
    exp_t  got, e;
    do_reset();
    s.push_back(mk(0, 0, 0, 1, 0)); q.push_back(ex(FRZ, 0, 0, 0));
    for (int k = 1; k <= 4; k++) begin
      s.push_back(mk(0, 0, 0, 0, 0)); q.push_back(ex(FRZ, 0, k, 0));
    end
    // ERROR: freeze regardless of mem_ready or branch.
    s.push_back(mk(0, 0, 1, 1, 1)); q.push_back(ex(FRZ, 1, 5, 0));
    s.push_back(mk(0, 1, 0, 0, 1)); q.push_back(ex(FRZ, 1, 6, 0));
    // One-cycle reset pulse clears everything.
    s.push_back(mk(1, 0, 0, 0, 0)); q.push_back(ex(RST, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0)); q.push_back(ex(DEF, 0, 0, 0));
    // Reset in the middle of a wait returns to RUN.
    s.push_back(mk(0, 0, 0, 1, 0)); q.push_back(ex(FRZ, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0)); q.push_back(ex(FRZ, 0, 1, 0));
    s.push_back(mk(1, 0, 0, 0, 0)); q.push_back(ex(RST, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0)); q.push_back(ex(DEF, 0, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i], q[i]);
      @(negedge clk); got = sample(); e = sb.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL timeout[%0d] got=%h exp=%h", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    stim_t s[$];
    exp_t  q[$];
    exp_t  got, e;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      s.push_back(mk(0, 1, 0, 0, 0)); q.push_back(ex(LU, 0, (k > 15) ? 15 : k, 0));
    end
    s.push_back(mk(0, 0, 0, 0, 0)); q.push_back(ex(DEF, 0, 15, 0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i], q[i]);
      @(negedge clk); got = sample(); e = sb.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL saturation[%0d] got=%h exp=%h", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[$];
    exp_t  q[$];
    exp_t  got, e;
    do_reset();
    s.push_back(mk(0, 0, 1, 0, 0)); q.push_back(ex(BR,  0, 0, 0));
    s.push_back(mk(0, 1, 0, 0, 0)); q.push_back(ex(LU,  0, 0, 1));
    s.push_back(mk(0, 0, 1, 0, 0)); q.push_back(ex(BR,  0, 1, 1));
    s.push_back(mk(0, 0, 0, 0, 0)); q.push_back(ex(DEF, 0, 1, 2));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i], q[i]);
      @(negedge clk); got = sample(); e = sb.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL back_to_back[%0d] got=%h exp=%h", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0; ex_branch_taken = 0;
    mem_req = 0; mem_ready = 0;
    test_reset();
    test_load_use();
    test_x0_unused();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
